// File: rtl/ibex_pkg.sv
// ibex_pkg (slice)
// Shared types and constants for the CV-X-IF memory interface as seen by
// the Ibex core. Only the parts used by the X-IF memory responder live here.
//   x_mem_req_t    : coprocessor memory request (id, addr, mode, we, size,
//                    be, attr, wdata, last, spec)
//   x_mem_resp_t   : synchronous response to an accepted request
//   x_mem_result_t : asynchronous result returned after the bus access
package ibex_pkg;

    parameter int unsigned X_ID_WIDTH = 4;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [31:0]           addr;
        logic [1:0]            mode;
        logic                  we;
        logic [2:0]            size;
        logic [3:0]            be;
        logic [1:0]            attr;
        logic [31:0]           wdata;
        logic                  last;
        logic                  spec;
    } x_mem_req_t;

    typedef struct packed {
        logic       exc;
        logic [5:0] exccode;
        logic       dbg;
    } x_mem_resp_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [31:0]           rdata;
        logic                  err;
        logic                  dbg;
    } x_mem_result_t;

    // Synchronous exception causes raised on the X-IF memory response.
    localparam logic [5:0] EXC_CAUSE_LOAD_ADDR_MISALIGNED  = 6'd4;
    localparam logic [5:0] EXC_CAUSE_LOAD_ACCESS_FAULT     = 6'd5;
    localparam logic [5:0] EXC_CAUSE_STORE_ADDR_MISALIGNED = 6'd6;
    localparam logic [5:0] EXC_CAUSE_STORE_ACCESS_FAULT    = 6'd7;

endpackage

// File: rtl/ibex_x_mem_align.sv
// ibex_x_mem_align
// Purely combinational byte-lane logic for sub-word accesses.
//   req_offset_i / req_size_i / req_wdata_i : request side, gives be_o,
//       lane-steered wdata_o and the misaligned_o flag
//   rsp_offset_i / rsp_rdata_i              : response side, gives rdata_o
//       shifted down so the addressed byte lands in bits [7:0]
module ibex_x_mem_align (
    input  logic [1:0]  req_offset_i,
    input  logic [2:0]  req_size_i,
    input  logic [31:0] req_wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o,
    input  logic [1:0]  rsp_offset_i,
    input  logic [31:0] rsp_rdata_i,
    output logic [31:0] rdata_o
);

    always_comb begin
        be_o = 4'b0000;
        case (req_size_i)
            3'd0:    be_o = 4'b0001 << req_offset_i;
            3'd1:    be_o = 4'b0011 << req_offset_i;
            3'd2:    be_o = 4'b1111;
            default: be_o = 4'b0000;
        endcase
    end

    // Sizes above a word are never legal on a 32-bit bus.
    assign misaligned_o = ((req_size_i == 3'd1) && req_offset_i[0]) ||
                          ((req_size_i == 3'd2) && (req_offset_i != 2'b00)) ||
                          (req_size_i >= 3'd3);

    assign wdata_o = req_wdata_i << {req_offset_i, 3'b000};
    assign rdata_o = rsp_rdata_i >> {rsp_offset_i, 3'b000};

endmodule

// File: rtl/ibex_x_mem_responder.sv
// ibex_x_mem_responder
// Core-side responder for the CV-X-IF memory / memory-result interfaces.
// Serves one coprocessor load/store at a time on the Ibex data bus.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   x_mem_valid_i/ready_o    : request handshake, x_mem_req_i payload
//   x_mem_resp_o             : exception info, valid only while valid&&ready
//   x_mem_result_valid_o/_o  : one-cycle result pulse (no back-pressure)
//   data_*                   : Ibex data bus (req/gnt, then rvalid)
//
// Handshakes: a request transfers in the cycle x_mem_valid_i && x_mem_ready_o;
// ready is only offered in IDLE and never for a speculative request, so a
// killed request that is withdrawn simply never transfers. On the bus side
// data_req_o and its payload are held until data_gnt_i, and exactly one
// data_rvalid_i is expected in a later cycle.
module ibex_x_mem_responder
    import ibex_pkg::*;
#(
    parameter logic [31:0] MemBase = 32'h0000_0000,
    parameter logic [31:0] MemSize = 32'h0010_0000
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          x_mem_valid_i,
    output logic          x_mem_ready_o,
    input  x_mem_req_t    x_mem_req_i,
    output x_mem_resp_t   x_mem_resp_o,
    output logic          x_mem_result_valid_o,
    output x_mem_result_t x_mem_result_o,
    output logic          data_req_o,
    input  logic          data_gnt_i,
    input  logic          data_rvalid_i,
    output logic [31:0]   data_addr_o,
    output logic          data_we_o,
    output logic [3:0]    data_be_o,
    output logic [31:0]   data_wdata_o,
    input  logic [31:0]   data_rdata_i,
    input  logic          data_err_i
);

    typedef enum logic [1:0] {IDLE, BUS_REQ, BUS_WAIT, RESULT} state_e;

    state_e                state_q, state_d;
    logic [X_ID_WIDTH-1:0] id_q;
    logic                  we_q;
    logic [1:0]            offset_q;
    logic [29:0]           addr_q;
    logic [3:0]            be_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic                  err_q;

    logic        accept, start, misaligned, out_of_range, exc;
    logic [3:0]  be_steered;
    logic [31:0] wdata_steered, rdata_shifted, addr_rel;
    logic [5:0]  exccode;
    logic        unused_inputs;

    assign unused_inputs = ^{x_mem_req_i.mode, x_mem_req_i.attr, x_mem_req_i.last, x_mem_req_i.be};

    ibex_x_mem_align u_align (
        .req_offset_i (x_mem_req_i.addr[1:0]),
        .req_size_i   (x_mem_req_i.size),
        .req_wdata_i  (x_mem_req_i.wdata),
        .be_o         (be_steered),
        .wdata_o      (wdata_steered),
        .misaligned_o (misaligned),
        .rsp_offset_i (offset_q),
        .rsp_rdata_i  (data_rdata_i),
        .rdata_o      (rdata_shifted)
    );

    // Unsigned wrap makes addresses below MemBase land far above MemSize.
    assign addr_rel     = x_mem_req_i.addr - MemBase;
    assign out_of_range = (addr_rel >= MemSize);
    assign exc          = misaligned || out_of_range;

    assign accept = (state_q == IDLE) && x_mem_valid_i && !x_mem_req_i.spec;
    assign start  = accept && !exc;

    // Misaligned takes priority over out-of-range.
    always_comb begin
        exccode = '0;
        if (misaligned) begin
            exccode = x_mem_req_i.we ? EXC_CAUSE_STORE_ADDR_MISALIGNED : EXC_CAUSE_LOAD_ADDR_MISALIGNED;
        end else if (out_of_range) begin
            exccode = x_mem_req_i.we ? EXC_CAUSE_STORE_ACCESS_FAULT : EXC_CAUSE_LOAD_ACCESS_FAULT;
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start) state_d = BUS_REQ;
            BUS_REQ:  if (data_gnt_i) state_d = BUS_WAIT;
            BUS_WAIT: if (data_rvalid_i) state_d = RESULT;
            RESULT:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output logic: bus and result payloads come from registers only.
    always_comb begin
        x_mem_ready_o        = accept;
        x_mem_resp_o         = '0;
        data_req_o           = 1'b0;
        data_addr_o          = '0;
        data_we_o            = 1'b0;
        data_be_o            = '0;
        data_wdata_o         = '0;
        x_mem_result_valid_o = 1'b0;
        x_mem_result_o       = '0;
        if (accept && exc) begin
            x_mem_resp_o.exc     = 1'b1;
            x_mem_resp_o.exccode = exccode;
        end
        if (state_q == BUS_REQ) begin
            data_req_o   = 1'b1;
            data_addr_o  = {addr_q, 2'b00};
            data_we_o    = we_q;
            data_be_o    = be_q;
            data_wdata_o = wdata_q;
        end
        if (state_q == RESULT) begin
            x_mem_result_valid_o = 1'b1;
            x_mem_result_o.id    = id_q;
            x_mem_result_o.rdata = rdata_q;
            x_mem_result_o.err   = err_q;
        end
    end

    // Access context, captured on accept and on the bus response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_q     <= '0;
            we_q     <= 1'b0;
            offset_q <= '0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (start) begin
                id_q     <= x_mem_req_i.id;
                we_q     <= x_mem_req_i.we;
                offset_q <= x_mem_req_i.addr[1:0];
                addr_q   <= x_mem_req_i.addr[31:2];
                be_q     <= be_steered;
                wdata_q  <= wdata_steered;
            end
            if ((state_q == BUS_WAIT) && data_rvalid_i) begin
                rdata_q <= we_q ? 32'h0 : rdata_shifted;
                err_q   <= data_err_i;
            end
        end
    end

endmodule

// File: tb/tb_ibex_x_mem_responder.sv
// tb_ibex_x_mem_responder
// Directed bench for ibex_x_mem_responder: acts as coprocessor and as data
// bus, checks the bus side per access and the result stream via a queue.
module tb_ibex_x_mem_responder;
    import ibex_pkg::*;

    logic          clk;
    logic          rst_n;
    logic          x_mem_valid;
    logic          x_mem_ready;
    x_mem_req_t    req;
    x_mem_resp_t   resp;
    logic          res_valid;
    x_mem_result_t res;
    logic          data_req;
    logic          data_gnt;
    logic          data_rvalid;
    logic [31:0]   data_addr;
    logic          data_we;
    logic [3:0]    data_be;
    logic [31:0]   data_wdata;
    logic [31:0]   data_rdata;
    logic          data_err;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int req_cnt = 0;
    logic [63:0] exp_q[$];

    ibex_x_mem_responder dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .x_mem_valid_i        (x_mem_valid),
        .x_mem_ready_o        (x_mem_ready),
        .x_mem_req_i          (req),
        .x_mem_resp_o         (resp),
        .x_mem_result_valid_o (res_valid),
        .x_mem_result_o       (res),
        .data_req_o           (data_req),
        .data_gnt_i           (data_gnt),
        .data_rvalid_i        (data_rvalid),
        .data_addr_o          (data_addr),
        .data_we_o            (data_we),
        .data_be_o            (data_be),
        .data_wdata_o         (data_wdata),
        .data_rdata_i         (data_rdata),
        .data_err_i           (data_err)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (data_req) req_cnt <= req_cnt + 1;

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every result pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (res_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 64'(1), 64'(0));
            end else begin
                chk("result", {27'b0, res.id, res.rdata, res.err}, exp_q.pop_front());
                chk("result_dbg", 64'(res.dbg), 64'(0));
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        x_mem_valid = 1'b0;
        req         = '0;
        data_gnt    = 1'b0;
        data_rvalid = 1'b0;
        data_rdata  = '0;
        data_err    = 1'b0;
    endtask

    task automatic set_req(input logic [3:0] id, input logic [31:0] addr, input logic we,
                           input logic [2:0] size, input logic [31:0] wdata, input logic spec);
        req.id    = id;
        req.addr  = addr;
        req.we    = we;
        req.size  = size;
        req.wdata = wdata;
        req.spec  = spec;
        req.mode  = 2'($urandom_range(0, 3));
        req.attr  = 2'($urandom_range(0, 3));
        req.be    = 4'($urandom_range(0, 15));
        req.last  = 1'($urandom_range(0, 1));
        x_mem_valid = 1'b1;
    endtask

    task automatic check_bus(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd, input logic we);
        chk("data_req", 64'(data_req), 64'(1));
        chk("data_addr", 64'(data_addr), 64'(a));
        chk("data_be", 64'(data_be), 64'(be));
        chk("data_wdata", 64'(data_wdata), 64'(wd));
        chk("data_we", 64'(data_we), 64'(we));
        chk("busy_ready", 64'(x_mem_ready), 64'(0));
    endtask

    task automatic do_access(input logic [3:0] id, input logic [31:0] addr, input logic we,
                             input logic [2:0] size, input logic [31:0] wdata, input int spec_hold,
                             input int gnt_wait, input logic [31:0] bus_rdata, input logic bus_err,
                             input logic [31:0] exp_addr, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
        int acc_cyc;
        set_req(id, addr, we, size, wdata, spec_hold > 0);
        for (int i = 0; i < spec_hold; i++) begin
            #1;
            chk("spec_ready", 64'(x_mem_ready), 64'(0));
            chk("spec_bus", 64'(data_req), 64'(0));
            tick();
        end
        req.spec = 1'b0;
        #1;
        chk("accept_ready", 64'(x_mem_ready), 64'(1));
        chk("accept_exc", 64'(resp.exc), 64'(0));
        chk("accept_exccode", 64'(resp.exccode), 64'(0));
        acc_cyc = cyc;
        exp_q.push_back({27'b0, id, exp_rdata, bus_err});
        tick();
        x_mem_valid = 1'b0;
        for (int i = 0; i < gnt_wait; i++) begin
            #1;
            check_bus(exp_addr, exp_be, exp_wdata, we);
            tick();
        end
        data_gnt = 1'b1;
        #1;
        check_bus(exp_addr, exp_be, exp_wdata, we);
        tick();
        data_gnt = 1'b0;
        #1;
        chk("wait_req_low", 64'(data_req), 64'(0));
        data_rvalid = 1'b1;
        data_rdata  = bus_rdata;
        data_err    = bus_err;
        tick();
        data_rvalid = 1'b0;
        data_rdata  = '0;
        data_err    = 1'b0;
        // A fresh legal request during RESULT must not be accepted.
        set_req(4'hF, 32'h0000_0040, 1'b0, 3'd2, 32'h0, 1'b0);
        #1;
        chk("result_valid", 64'(res_valid), 64'(1));
        chk("result_ready", 64'(x_mem_ready), 64'(0));
        chk("latency", 64'(cyc - acc_cyc + 1), 64'(4 + gnt_wait));
        x_mem_valid = 1'b0;
        tick();
        #1;
        chk("result_one_cycle", 64'(res_valid), 64'(0));
    endtask

    task automatic do_exc(input logic [31:0] addr, input logic we, input logic [2:0] size, input logic [5:0] code);
        int rc;
        rc = req_cnt;
        set_req(4'd7, addr, we, size, 32'hFFFF_FFFF, 1'b0);
        #1;
        chk("exc_ready", 64'(x_mem_ready), 64'(1));
        chk("exc_flag", 64'(resp.exc), 64'(1));
        chk("exc_code", 64'(resp.exccode), 64'(code));
        chk("exc_dbg", 64'(resp.dbg), 64'(0));
        tick();
        x_mem_valid = 1'b0;
        tick();
        tick();
        chk("exc_no_bus", 64'(req_cnt), 64'(rc));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, 64'(x_mem_ready), 64'(0));
        chk({tag, "_resp"}, 64'(resp), 64'(0));
        chk({tag, "_res_valid"}, 64'(res_valid), 64'(0));
        chk({tag, "_result"}, 64'(res), 64'(0));
        chk({tag, "_bus"}, {data_req, data_we, data_be, data_addr}, 64'(0));
        chk({tag, "_wdata"}, 64'(data_wdata), 64'(0));
    endtask

    initial begin
        int rc;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Load word, minimum latency
        do_access(4'd3, 32'h0000_0100, 1'b0, 3'd2, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0,
                  32'h0000_0100, 4'b1111, 32'h0, 32'hDEAD_BEEF);
        // Store byte in the top lane, one grant-wait cycle
        do_access(4'd5, 32'h0000_0203, 1'b1, 3'd0, 32'h0000_00A5, 0, 1, 32'h1122_3344, 1'b0,
                  32'h0000_0200, 4'b1000, 32'hA500_0000, 32'h0);
        // Store half in the upper half-word
        do_access(4'd6, 32'h0000_0302, 1'b1, 3'd1, 32'h1234_BEEF, 0, 2, 32'hFFFF_FFFF, 1'b0,
                  32'h0000_0300, 4'b1100, 32'hBEEF_0000, 32'h0);
        // Speculative for 5 cycles, then committed
        do_access(4'd1, 32'h0000_0010, 1'b0, 3'd2, 32'h0, 5, 0, 32'hCAFE_F00D, 1'b0,
                  32'h0000_0010, 4'b1111, 32'h0, 32'hCAFE_F00D);
        // Back-pressure, bus error, upper half-word load
        do_access(4'd9, 32'h0000_0102, 1'b0, 3'd1, 32'h0, 0, 6, 32'h1234_5678, 1'b1,
                  32'h0000_0100, 4'b1100, 32'h0, 32'h0000_1234);

        // Exceptions
        do_exc(32'h0000_0101, 1'b0, 3'd1, 6'd4);
        do_exc(32'h0010_0000, 1'b1, 3'd2, 6'd7);
        do_exc(32'h0010_0002, 1'b0, 3'd2, 6'd4);
        do_exc(32'h0000_0000, 1'b1, 3'd3, 6'd6);
        do_exc(32'hFFFF_FFFF, 1'b0, 3'd0, 6'd5);
        do_exc(32'h000F_FFFF, 1'b1, 3'd1, 6'd6);

        // Speculative request withdrawn after a kill
        rc = req_cnt;
        set_req(4'd4, 32'h0000_0080, 1'b0, 3'd2, 32'h0, 1'b1);
        #1;
        chk("withdraw_ready", 64'(x_mem_ready), 64'(0));
        tick();
        tick();
        x_mem_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("withdraw_no_bus", 64'(req_cnt), 64'(rc));

        // Reset while waiting for rvalid
        set_req(4'd2, 32'h0000_0400, 1'b0, 3'd2, 32'h0, 1'b0);
        tick();
        x_mem_valid = 1'b0;
        data_gnt    = 1'b1;
        tick();
        data_gnt = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_all_zero("midreset");
        data_rvalid = 1'b1;
        data_rdata  = 32'h5555_AAAA;
        tick();
        data_rvalid = 1'b0;
        data_rdata  = '0;
        rst_n       = 1'b1;
        tick();
        tick();
        chk("midreset_idle_bus", 64'(data_req), 64'(0));

        // Recovery: byte load from lane 1
        do_access(4'hA, 32'h0000_0101, 1'b0, 3'd0, 32'h0, 0, 0, 32'hAABB_CCDD, 1'b0,
                  32'h0000_0100, 4'b0010, 32'h0, 32'h00AA_BBCC);

        tick();
        tick();
        chk("pending_results", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ibex_x_mem_responder.md
Name: ibex_x_mem_responder

Overview:
Core-side responder for the CV-X-IF memory and memory-result interfaces. It serves one coprocessor load/store at a time and maps it onto the standard Ibex data bus (req/gnt/rvalid).
- Alignment: byte-lane steering for sub-word accesses.
- Checks: misalignment and address-range checks, which raise a synchronous exception.
- Return path: read data or a bus error goes back on x_mem_result.
- Placement: between the X-IF coprocessor port (for example the load/store accelerator) and the data-bus arbiter.

Parameters:
MemBase, 32'h0000_0000, lowest legal byte address
MemSize, 32'h0010_0000, size of the legal window in bytes; legal iff (addr - MemBase) < MemSize, unsigned 32-bit arithmetic

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
x_mem_valid_i  in  1  coprocessor memory request valid
x_mem_ready_o  out  1  request accepted
x_mem_req_i  in  x_mem_req_t  id, addr, mode, we, size, be, attr, wdata, last, spec
x_mem_resp_o  out  x_mem_resp_t  exc, exccode, dbg; meaningful only while valid&&ready
x_mem_result_valid_o  out  1  one-cycle result pulse; no ready
x_mem_result_o  out  x_mem_result_t  id, rdata, err, dbg
data_req_o  out  1  bus request
data_gnt_i  in  1  bus grant
data_rvalid_i  in  1  bus response valid
data_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
data_we_o  out  1  write enable
data_be_o  out  4  byte enables
data_wdata_o  out  32  lane-steered write data
data_rdata_i  in  32  read data
data_err_i  in  1  bus error, sampled with rvalid

Behaviour:
- Reset values:
  - FSM in IDLE.
  - All outputs 0: x_mem_ready_o, x_mem_result_valid_o, data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o, resp and result fields.
- FSM states: IDLE, BUS_REQ, BUS_WAIT, RESULT.
- IDLE, accept rule:
  - x_mem_ready_o = x_mem_valid_i && !x_mem_req_i.spec, combinational.
  - Speculative requests are stalled until the initiator clears spec after commit.
  - A withdrawn request (valid drops after a kill) has no effect.
- On accept with exception (misaligned or out-of-range):
  - resp.exc=1 in the same cycle.
  - Stay in IDLE; no bus access and no result.
- Exception codes:
  - Load: misaligned 4, out-of-range 5.
  - Store: misaligned 6, out-of-range 7.
  - Misaligned has priority over out-of-range.
- Misaligned is defined as any of:
  - size=1 with addr[0]=1
  - size=2 with addr[1:0]!=0
  - size>=3
- On accept without exception:
  - resp.exc=0, exccode=0.
  - Register id, we, offset=addr[1:0], size, word address, be, wdata.
  - Go to BUS_REQ.
- Byte enables (req.be is ignored):
  - size0: 4'b0001<<offset
  - size1: 4'b0011<<offset
  - size2: 4'b1111
- Write data: wdata<<(8*offset), truncated to 32 bits.
- BUS_REQ:
  - data_req_o=1, driven from registers only.
  - Hold all bus outputs stable until data_gnt_i.
  - On grant go to BUS_WAIT.
  - rvalid in the grant cycle is not legal.
- BUS_WAIT:
  - data_req_o=0.
  - On data_rvalid_i, register rdata = data_rdata_i>>(8*offset) and err = data_err_i, then go to RESULT.
  - Stores also wait for rvalid; their rdata is don't-care, forced to 0.
- RESULT:
  - x_mem_result_valid_o=1 for exactly one cycle with the registered id, rdata and err; dbg=0.
  - Go to IDLE; x_mem_ready_o stays 0 in this cycle.
- Latency: accept to result pulse = 1 + grant wait + rvalid wait + 1 cycles. The minimum is 4 cycles when gnt comes in the first BUS_REQ cycle and rvalid the next cycle.
- Occupancy: one outstanding access; x_mem_ready_o=0 in every state except IDLE.
- Unused inputs: mode, attr, last and req.be are unused and sunk to unused_* signals. resp.dbg=0.
- Reset mid-operation: return to IDLE, drop the access, emit no result. A bus grant already given is the arbiter's responsibility.

Decomposition:
- Use the existing ibex_pkg types: x_mem_req_t, x_mem_resp_t, x_mem_result_t, X_ID_WIDTH.
- Add the exception-code constants to ibex_pkg if absent: EXC_CAUSE_LOAD_ADDR_MISALIGNED and EXC_CAUSE_STORE_ADDR_MISALIGNED.
- The FSM enum is local to the module.
- Sub-module ibex_x_mem_align: a purely combinational block that computes be, steered wdata, the misaligned flag and the read-data shift.

Test Plan:
- Load word: valid, addr=0x100, size=2, we=0, spec=0, id=3. Expect ready the same cycle. On gnt next cycle and rvalid with rdata=0xDEADBEEF, expect a result pulse with id=3, rdata=0xDEADBEEF, err=0, 4 cycles after accept.
- Store byte: addr=0x203, size=0, wdata=0x000000A5. Expect data_addr=0x200, be=4'b1000, wdata=0xA5000000, we=1, then one result pulse.
- Misaligned and out-of-range:
  - Load half at addr=0x101: expect ready=1, exc=1, exccode=4, no data_req, no result.
  - Store word at addr=MemBase+MemSize: expect exc=1, exccode=7.
- Speculation stall: hold valid with spec=1 for 5 cycles and expect ready=0 throughout. Drop spec and expect ready=1 that cycle. Separately, valid drops while spec=1: expect no bus activity.
- Back-pressure and error:
  - Hold gnt=0 for 6 cycles: data_req/addr/be stay stable.
  - Drive rvalid with data_err=1 and rdata=0x12345678 on addr=0x102, size=1: expect result err=1, rdata=0x00001234.
  - Assert rst_ni=0 during BUS_WAIT: expect all outputs 0, no result.
